tx_timer_param: RTL and testbench
=================================

Name: tx_timer_param

Overview:
- Programmable bit-period timer for the transmit path. It generalises the fixed 28-cycle / 10-bit transmit timer.
- Bit period and bits-per-frame are runtime inputs, latched at frame start. Counter widths are set by parameters.
- Generates per-bit shift strobes, a running bit count and a frame-done pulse, with a start/busy handshake and abort.
- Sits between the TX controller FSM and the TX shift register.

Parameters:
- PERIOD_BITS, 8: width of bit_period and of the internal cycle counter.
- COUNT_BITS, 5: width of num_bits and bit_count.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- n_rst  input  1  asynchronous, active-high reset (asserted = 1 resets the block).
- start  input  1  one-cycle request to begin a frame; ignored while busy=1.
- abort  input  1  synchronous cancel of the current frame.
- bit_period  input  PERIOD_BITS  clock cycles per bit; sampled when start is accepted.
- num_bits  input  COUNT_BITS  bits per frame; sampled when start is accepted.
- busy  output  1  high while a frame is being timed.
- shift_strobe  output  1  one-cycle pulse at the end of each bit period.
- bit_count  output  COUNT_BITS  number of strobes issued in the current or last frame.
- frame_done  output  1  one-cycle pulse coincident with the final shift_strobe.

Behaviour:
- Reset: state IDLE; busy, shift_strobe, frame_done = 0; bit_count = 0; internal cycle counter = 0. Reset is asynchronous and may be asserted mid-frame: the block returns to IDLE at once and emits no frame_done.
- States: IDLE, RUN.
- IDLE, start=1 and abort=0 at edge E0:
  - Latch P = max(bit_period, 2) and N = max(num_bits, 1).
  - Clear bit_count to 0 and set the cycle counter to 1.
  - busy = 1 after E0; go to RUN.
- RUN, per edge:
  - If the cycle counter == P: reset it to 1, increment bit_count, and assert shift_strobe for the following cycle.
  - Otherwise increment the cycle counter.
  - Result: strobe k (k = 1..N) is visible in the cycle after edge E0 + k*P, and bit_count = k in that same cycle.
- Frame end: on the edge that issues strobe N:
  - frame_done is asserted together with shift_strobe.
  - busy drops and the state returns to IDLE.
  - bit_count holds N until the next accepted start.
- Back-to-back frames: start sampled during the frame_done cycle is accepted (the FSM is already IDLE). The next frame's first strobe comes P' cycles later; there are no gap cycles.
- start while busy=1: ignored, no effect on counters or latched values.
- abort=1 at any edge:
  - Go to IDLE, clear bit_count and the cycle counter.
  - No shift_strobe or frame_done on that edge.
  - abort has priority over start and over a coinciding strobe.
- Changing bit_period or num_bits during RUN has no effect.
- Arithmetic: counters are unsigned and never wrap, because they compare against latched values. With P = 2^PERIOD_BITS − 1 and N = 2^COUNT_BITS − 1 the block must operate without overflow.

Optional Feature:
- Macro: TX_TIMER_MID_STROBE_EN.
- Defined:
  - Adds output port sample_strobe (1 bit, reset 0).
  - It pulses once per bit, in the cycle after the cycle counter reaches floor(P/2), only in RUN.
  - Used for mid-bit loopback checking.
  - Suppressed on any abort edge.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Basic frame: reset, then bit_period=28, num_bits=10, start pulse → 10 strobes spaced exactly 28 cycles apart, the first 28 cycles after the start edge. bit_count steps 1..10. frame_done coincides with strobe 10. busy is high for 280 cycles.
- Clamping: bit_period=0, num_bits=0 → behaves as P=2, N=1. One strobe 2 cycles after start, with frame_done.
- Back-to-back and busy-ignore: P=4, N=3, plus a second start during busy → the second start is ignored. Then a start in the frame_done cycle with P=5, N=2 → strobes at +5 and +10, with no gap. The latched P/N ignore input changes during RUN.
- Abort priority: P=8, N=4; assert abort on the same edge as strobe 2 → no strobe or frame_done on that edge, bit_count=0, busy=0. A start asserted together with abort is also ignored.
- Async reset mid-frame: assert n_rst=1 between clock edges at bit 3 of 10 → busy, bit_count and strobes go to 0 immediately. A restart after release behaves as a fresh frame.
- TX_TIMER_MID_STROBE_EN build: P=7, N=2 → sample_strobe 3 cycles after each bit start. With the macro undefined, the design elaborates without the port.

Source files
------------

// File: rtl/tx_timer_param.sv
// Programmable bit-period timer for the transmit path.
// Bit period and bits-per-frame are latched when a frame starts. The block produces
// per-bit shift strobes, a running bit count and a frame-done pulse.
// Optional build macro: TX_TIMER_MID_STROBE_EN adds sample_strobe_o, a mid-bit pulse.
module tx_timer_param #(
   parameter int unsigned PERIOD_BITS = 8,
   parameter int unsigned COUNT_BITS  = 5
) (
   input  logic                   clk_i,
   input  logic                   n_rst_i,         // active-high asynchronous reset
   input  logic                   start_i,
   input  logic                   abort_i,
   input  logic [PERIOD_BITS-1:0] bit_period_i,
   input  logic [COUNT_BITS-1:0]  num_bits_i,
   output logic                   busy_o,
   output logic                   shift_strobe_o,
   output logic [COUNT_BITS-1:0]  bit_count_o,
   output logic                   frame_done_o
`ifdef TX_TIMER_MID_STROBE_EN
   ,
   output logic                   sample_strobe_o
`endif
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   localparam logic [PERIOD_BITS-1:0] MinPeriod = PERIOD_BITS'(2);
   localparam logic [PERIOD_BITS-1:0] CntOne    = PERIOD_BITS'(1);
   localparam logic [COUNT_BITS-1:0]  MinBits   = COUNT_BITS'(1);

   state_e                  state_q, state_d;
   logic [PERIOD_BITS-1:0]  period_q, period_d;
   logic [COUNT_BITS-1:0]   nbits_q, nbits_d;
   logic [PERIOD_BITS-1:0]  cnt_q, cnt_d;
   logic [COUNT_BITS-1:0]   bit_count_q, bit_count_d;
   logic                    strobe_q, strobe_d;
   logic                    done_q, done_d;
   logic [COUNT_BITS-1:0]   bit_count_inc;
`ifdef TX_TIMER_MID_STROBE_EN
   logic                    mid_q, mid_d;
`endif

   assign bit_count_inc = bit_count_q + MinBits;

   // Next-state: frame acceptance, per-cycle bit timing, abort priority.
   always_comb begin
      state_d     = state_q;
      period_d    = period_q;
      nbits_d     = nbits_q;
      cnt_d       = cnt_q;
      bit_count_d = bit_count_q;
      strobe_d    = 1'b0;
      done_d      = 1'b0;
`ifdef TX_TIMER_MID_STROBE_EN
      mid_d       = 1'b0;
`endif
      if (abort_i) begin
         // Abort wins over start and over a coinciding strobe.
         state_d     = StIdle;
         cnt_d       = '0;
         bit_count_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  period_d    = (bit_period_i < MinPeriod) ? MinPeriod : bit_period_i;
                  nbits_d     = (num_bits_i == '0) ? MinBits : num_bits_i;
                  cnt_d       = CntOne;
                  bit_count_d = '0;
                  state_d     = StRun;
               end
            end
            StRun: begin
`ifdef TX_TIMER_MID_STROBE_EN
               mid_d = (cnt_q == (period_q >> 1));
`endif
               if (cnt_q == period_q) begin
                  cnt_d       = CntOne;
                  bit_count_d = bit_count_inc;
                  strobe_d    = 1'b1;
                  if (bit_count_inc == nbits_q) begin
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end
               end else begin
                  cnt_d = cnt_q + CntOne;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and counter registers with asynchronous clear.
   always_ff @(posedge clk_i or posedge n_rst_i) begin
      if (n_rst_i) begin
         state_q     <= StIdle;
         period_q    <= MinPeriod;
         nbits_q     <= MinBits;
         cnt_q       <= '0;
         bit_count_q <= '0;
         strobe_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         period_q    <= period_d;
         nbits_q     <= nbits_d;
         cnt_q       <= cnt_d;
         bit_count_q <= bit_count_d;
         strobe_q    <= strobe_d;
         done_q      <= done_d;
      end
   end

`ifdef TX_TIMER_MID_STROBE_EN
   // Mid-bit sample pulse register.
   always_ff @(posedge clk_i or posedge n_rst_i) begin
      if (n_rst_i) begin
         mid_q <= 1'b0;
      end else begin
         mid_q <= mid_d;
      end
   end

   assign sample_strobe_o = mid_q;
`endif

   assign busy_o         = (state_q == StRun);
   assign shift_strobe_o = strobe_q;
   assign frame_done_o   = done_q;
   assign bit_count_o    = bit_count_q;

endmodule

// File: tb/tb_tx_timer_param.sv
// Directed self-checking bench for tx_timer_param.
// Define TX_TIMER_MID_STROBE_EN to also exercise sample_strobe_o.
module tb_tx_timer_param;

   logic       clk_i = 1'b0;
   logic       n_rst_i = 1'b1;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic [7:0] bit_period_i = '0;
   logic [4:0] num_bits_i = '0;
   logic       busy_o;
   logic       shift_strobe_o;
   logic [4:0] bit_count_o;
   logic       frame_done_o;
`ifdef TX_TIMER_MID_STROBE_EN
   logic       sample_strobe_o;
`endif

   int checks = 0;
   int failures = 0;

   tx_timer_param #(
      .PERIOD_BITS(8),
      .COUNT_BITS (5)
   ) dut (
      .clk_i          (clk_i),
      .n_rst_i        (n_rst_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .bit_period_i   (bit_period_i),
      .num_bits_i     (num_bits_i),
      .busy_o         (busy_o),
      .shift_strobe_o (shift_strobe_o),
      .bit_count_o    (bit_count_o),
      .frame_done_o   (frame_done_o)
`ifdef TX_TIMER_MID_STROBE_EN
      ,
      .sample_strobe_o(sample_strobe_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   // Advance one clock edge; inputs change and outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      n_rst_i = 1'b1;
      #12;
      checks++;
      if (busy_o !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b want=0", busy_o);
      end
      checks++;
      if (shift_strobe_o !== 1'b0 || frame_done_o !== 1'b0) begin
         failures++; $display("FAIL reset_pulses got=%b%b want=00", shift_strobe_o, frame_done_o);
      end
      checks++;
      if (bit_count_o !== 5'd0) begin
         failures++; $display("FAIL reset_count got=%0d want=0", bit_count_o);
      end
      n_rst_i = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int busy_cnt;
      int bad;
      bit_period_i = 8'd28; num_bits_i = 5'd10; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || bit_count_o !== 5'd0) begin
         failures++; $display("FAIL basic_start got busy=%b cnt=%0d want busy=1 cnt=0",
                              busy_o, bit_count_o);
      end
      busy_cnt = int'(busy_o);
      bad = 0;
      for (int k = 1; k <= 10; k++) begin
         for (int j = 1; j <= 28; j++) begin
            tick();
            busy_cnt += int'(busy_o);
            if (j < 28) begin
               if (shift_strobe_o !== 1'b0 || frame_done_o !== 1'b0) bad++;
            end else begin
               checks++;
               if (shift_strobe_o !== 1'b1 || bit_count_o !== 5'(k)) begin
                  failures++; $display("FAIL basic_strobe%0d got strb=%b cnt=%0d want strb=1 cnt=%0d",
                                       k, shift_strobe_o, bit_count_o, k);
               end
               checks++;
               if (frame_done_o !== (k == 10) || busy_o !== (k != 10)) begin
                  failures++; $display("FAIL basic_done%0d got done=%b busy=%b want done=%b busy=%b",
                                       k, frame_done_o, busy_o, k == 10, k != 10);
               end
            end
         end
      end
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL basic_spurious got=%0d want=0", bad);
      end
      checks++;
      if (busy_cnt != 280) begin
         failures++; $display("FAIL basic_busy_cycles got=%0d want=280", busy_cnt);
      end
      tick();
      checks++;
      if (bit_count_o !== 5'd10 || shift_strobe_o !== 1'b0) begin
         failures++; $display("FAIL basic_hold got cnt=%0d strb=%b want cnt=10 strb=0",
                              bit_count_o, shift_strobe_o);
      end
   endtask

   task automatic test_clamp();
      bit_period_i = 8'd0; num_bits_i = 5'd0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      checks++;
      if (shift_strobe_o !== 1'b0 || busy_o !== 1'b1) begin
         failures++; $display("FAIL clamp_early got strb=%b busy=%b want strb=0 busy=1",
                              shift_strobe_o, busy_o);
      end
      tick();
      checks++;
      if (shift_strobe_o !== 1'b1 || frame_done_o !== 1'b1 || bit_count_o !== 5'd1 ||
          busy_o !== 1'b0) begin
         failures++; $display("FAIL clamp_strobe got strb=%b done=%b cnt=%0d busy=%b want 1 1 1 0",
                              shift_strobe_o, frame_done_o, bit_count_o, busy_o);
      end
      tick();
      checks++;
      if (bit_count_o !== 5'd1 || shift_strobe_o !== 1'b0) begin
         failures++; $display("FAIL clamp_hold got cnt=%0d strb=%b want cnt=1 strb=0",
                              bit_count_o, shift_strobe_o);
      end
   endtask

   task automatic test_back_to_back();
      bit_period_i = 8'd4; num_bits_i = 5'd3; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int t = 1; t <= 12; t++) begin
         if (t == 3) begin
            start_i = 1'b1; bit_period_i = 8'd9; num_bits_i = 5'd7;
         end else begin
            start_i = 1'b0; bit_period_i = 8'd1; num_bits_i = 5'd1;
         end
         tick();
         checks++;
         if (shift_strobe_o !== (t % 4 == 0)) begin
            failures++; $display("FAIL b2b_a_strobe t=%0d got=%b want=%b",
                                 t, shift_strobe_o, t % 4 == 0);
         end
      end
      start_i = 1'b0;
      checks++;
      if (frame_done_o !== 1'b1 || bit_count_o !== 5'd3) begin
         failures++; $display("FAIL b2b_a_done got done=%b cnt=%0d want done=1 cnt=3",
                              frame_done_o, bit_count_o);
      end
      // Start during the frame_done cycle.
      bit_period_i = 8'd5; num_bits_i = 5'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0; bit_period_i = 8'd1; num_bits_i = 5'd9;
      checks++;
      if (busy_o !== 1'b1 || bit_count_o !== 5'd0 || shift_strobe_o !== 1'b0) begin
         failures++; $display("FAIL b2b_b_start got busy=%b cnt=%0d strb=%b want 1 0 0",
                              busy_o, bit_count_o, shift_strobe_o);
      end
      for (int t = 1; t <= 10; t++) begin
         tick();
         checks++;
         if (shift_strobe_o !== (t % 5 == 0) || frame_done_o !== (t == 10)) begin
            failures++; $display("FAIL b2b_b t=%0d got strb=%b done=%b want strb=%b done=%b",
                                 t, shift_strobe_o, frame_done_o, t % 5 == 0, t == 10);
         end
      end
      checks++;
      if (bit_count_o !== 5'd2 || busy_o !== 1'b0) begin
         failures++; $display("FAIL b2b_b_end got cnt=%0d busy=%b want cnt=2 busy=0",
                              bit_count_o, busy_o);
      end
   endtask

   task automatic test_abort();
      bit_period_i = 8'd8; num_bits_i = 5'd4; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int t = 1; t <= 15; t++) tick();
      checks++;
      if (bit_count_o !== 5'd1 || busy_o !== 1'b1) begin
         failures++; $display("FAIL abort_pre got cnt=%0d busy=%b want cnt=1 busy=1",
                              bit_count_o, busy_o);
      end
      abort_i = 1'b1; start_i = 1'b1;
      tick();
      abort_i = 1'b0; start_i = 1'b0;
      checks++;
      if (shift_strobe_o !== 1'b0 || frame_done_o !== 1'b0) begin
         failures++; $display("FAIL abort_pulses got strb=%b done=%b want 0 0",
                              shift_strobe_o, frame_done_o);
      end
      checks++;
      if (bit_count_o !== 5'd0 || busy_o !== 1'b0) begin
         failures++; $display("FAIL abort_state got cnt=%0d busy=%b want cnt=0 busy=0",
                              bit_count_o, busy_o);
      end
      tick();
      checks++;
      if (busy_o !== 1'b0) begin
         failures++; $display("FAIL abort_start_ignored got busy=%b want=0", busy_o);
      end
   endtask

   task automatic test_async_reset();
      bit_period_i = 8'd6; num_bits_i = 5'd10; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int t = 1; t <= 12; t++) tick();
      checks++;
      if (shift_strobe_o !== 1'b1 || bit_count_o !== 5'd2) begin
         failures++; $display("FAIL rst_pre got strb=%b cnt=%0d want strb=1 cnt=2",
                              shift_strobe_o, bit_count_o);
      end
      #2 n_rst_i = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b0 || bit_count_o !== 5'd0 || shift_strobe_o !== 1'b0 ||
          frame_done_o !== 1'b0) begin
         failures++; $display("FAIL rst_async got busy=%b cnt=%0d strb=%b done=%b want 0 0 0 0",
                              busy_o, bit_count_o, shift_strobe_o, frame_done_o);
      end
      n_rst_i = 1'b0;
      bit_period_i = 8'd3; num_bits_i = 5'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      checks++;
      if (busy_o !== 1'b1 || bit_count_o !== 5'd0) begin
         failures++; $display("FAIL rst_restart got busy=%b cnt=%0d want busy=1 cnt=0",
                              busy_o, bit_count_o);
      end
      for (int t = 1; t <= 6; t++) begin
         tick();
         checks++;
         if (shift_strobe_o !== (t % 3 == 0) || frame_done_o !== (t == 6)) begin
            failures++; $display("FAIL rst_frame t=%0d got strb=%b done=%b want strb=%b done=%b",
                                 t, shift_strobe_o, frame_done_o, t % 3 == 0, t == 6);
         end
      end
   endtask

`ifdef TX_TIMER_MID_STROBE_EN
   task automatic test_mid_strobe();
      bit_period_i = 8'd7; num_bits_i = 5'd2; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int t = 1; t <= 15; t++) begin
         tick();
         checks++;
         if (sample_strobe_o !== (t == 3 || t == 10)) begin
            failures++; $display("FAIL mid_strobe t=%0d got=%b want=%b",
                                 t, sample_strobe_o, t == 3 || t == 10);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_back_to_back();
      test_abort();
      test_async_reset();
`ifdef TX_TIMER_MID_STROBE_EN
      test_mid_strobe();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
